// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder sweep checker.
//   state_e    : sweep FSM states
//   *_width()  : widths of the exact sum, the error, the error counter and the error accumulator
//                for a given operand width
package approx_pkg;

   typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

   // a + b for two w-bit operands needs one carry bit.
   function automatic int unsigned sum_width(input int unsigned w);
      return w + 1;
   endfunction

   // |po - exact| never exceeds the sum range.
   function automatic int unsigned err_width(input int unsigned w);
      return w + 1;
   endfunction

   // Counts up to 2^(2w) vectors inclusive.
   function automatic int unsigned cnt_width(input int unsigned w);
      return 2 * w + 1;
   endfunction

   // Holds 2^(2w) errors of up to 2^(w+1)-1 each.
   function automatic int unsigned acc_width(input int unsigned w);
      return 3 * w + 1;
   endfunction

endpackage

// File: rtl/approx_err_pipe.sv
// Delay line that aligns each vector's exact sum with the DUT response Depth cycles later.
//   clk_i   : clock
//   flush_i : synchronous clear of all valid flags
//   valid_i : vector driven this cycle
//   data_i  : vector id and exact sum of that vector
//   valid_o : delayed valid flag
//   data_o  : delayed data
// Depth = 0 is a combinational pass-through.
module approx_err_pipe #(
   parameter int unsigned DataW = 8,
   parameter int unsigned Depth = 1
) (
   input  logic             clk_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [DataW-1:0] data_i,
   output logic             valid_o,
   output logic [DataW-1:0] data_o
);

   if (Depth == 0) begin : g_bypass
      assign valid_o = valid_i;
      assign data_o  = data_i;
   end else begin : g_pipe
      logic [Depth-1:0] vld_q;
      logic [DataW-1:0] data_q [Depth];

      always_ff @(posedge clk_i) begin
         if (flush_i) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < int'(Depth); i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      // Data needs no clear: it is only consumed alongside a valid flag.
      always_ff @(posedge clk_i) begin
         data_q[0] <= data_i;
         for (int i = 1; i < int'(Depth); i++) begin
            data_q[i] <= data_q[i-1];
         end
      end

      assign valid_o = vld_q[Depth-1];
      assign data_o  = data_q[Depth-1];
   end

endmodule

// File: rtl/approx_adder_sweep_checker.sv
// Exhaustively sweeps all operand pairs of an approximate adder and gathers error statistics.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begins a sweep (ignored while busy)
//   abort_en            : stop at the first vector whose error exceeds WCE_LIMIT
//   dut_pi / dut_po     : stimulus {b, a} to the adder under test / its sum
//   busy, done, pass    : status; pass valid only while done
//   wce, err_count,
//   sum_abs_err         : worst-case error, count of erroneous vectors, total absolute error
//   fail_vector         : first vector exceeding WCE_LIMIT, 0 if none
module approx_adder_sweep_checker
   import approx_pkg::*;
#(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned WCE_LIMIT = 2,
   parameter int unsigned DUT_LAT   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort_en,
   output logic [2*WIDTH-1:0] dut_pi,
   input  logic [WIDTH:0]     dut_po,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [WIDTH:0]     wce,
   output logic [2*WIDTH:0]   err_count,
   output logic [3*WIDTH:0]   sum_abs_err,
   output logic [2*WIDTH-1:0] fail_vector
);

   localparam int unsigned PiW  = 2 * WIDTH;
   localparam int unsigned SumW = sum_width(WIDTH);
   localparam int unsigned ErrW = err_width(WIDTH);
   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam int unsigned AccW = acc_width(WIDTH);
   localparam logic [ErrW-1:0] Limit     = ErrW'(WCE_LIMIT);
   localparam logic [PiW-1:0]  LastVec   = '1;
   localparam logic [31:0]     DrainLast = (DUT_LAT == 0) ? 32'd0 : 32'(DUT_LAT - 1);

   state_e            state_q;
   logic [PiW-1:0]    pi_q;
   logic [PiW-1:0]    fail_vec_q;
   logic              fail_seen_q;
   logic [ErrW-1:0]   wce_q;
   logic [CntW-1:0]   cnt_q;
   logic [AccW-1:0]   sum_q;
   logic [31:0]       drain_q;

   logic [SumW-1:0]     exact_now;
   logic [SumW-1:0]     cmp_exact;
   logic [PiW-1:0]      cmp_vec;
   logic [PiW+SumW-1:0] cmp_data;
   logic                cmp_vld;
   logic                start_ok;
   logic                active;
   logic                violation;
   logic [ErrW-1:0]     err;

   assign exact_now = {1'b0, pi_q[WIDTH-1:0]} + {1'b0, pi_q[PiW-1:WIDTH]};
   assign start_ok  = start && (state_q == StIdle || state_q == StDone);

   // Restarting flushes stale compares left over from an aborted sweep.
   approx_err_pipe #(
      .DataW(PiW + SumW),
      .Depth(DUT_LAT)
   ) u_err_pipe (
      .clk_i  (clk),
      .flush_i(rst || start_ok),
      .valid_i(state_q == StSweep),
      .data_i ({pi_q, exact_now}),
      .valid_o(cmp_vld),
      .data_o (cmp_data)
   );

   assign cmp_vec   = cmp_data[PiW+SumW-1:SumW];
   assign cmp_exact = cmp_data[SumW-1:0];

   assign err = (dut_po >= cmp_exact) ? ErrW'(dut_po - cmp_exact) : ErrW'(cmp_exact - dut_po);

   // Compares arriving after an abort (state DONE) are discarded.
   assign active    = cmp_vld && (state_q == StSweep || state_q == StDrain);
   assign violation = active && (err > Limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pi_q        <= '0;
         wce_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         fail_vec_q  <= '0;
         fail_seen_q <= 1'b0;
         drain_q     <= '0;
      end else begin
         if (active) begin
            if (err > wce_q) wce_q <= err;
            if (err != '0) cnt_q <= cnt_q + CntW'(1);
            sum_q <= sum_q + AccW'(err);
            if (err > Limit && !fail_seen_q) begin
               fail_vec_q  <= cmp_vec;
               fail_seen_q <= 1'b1;
            end
         end
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q     <= StSweep;
                  pi_q        <= '0;
                  wce_q       <= '0;
                  cnt_q       <= '0;
                  sum_q       <= '0;
                  fail_vec_q  <= '0;
                  fail_seen_q <= 1'b0;
               end
            end
            StSweep: begin
               if (violation && abort_en) begin
                  state_q <= StDone;
               end else if (pi_q == LastVec) begin
                  drain_q <= '0;
                  state_q <= (DUT_LAT == 0) ? StDone : StDrain;
               end else begin
                  pi_q <= pi_q + PiW'(1);
               end
            end
            StDrain: begin
               if ((violation && abort_en) || drain_q == DrainLast) begin
                  state_q <= StDone;
               end else begin
                  drain_q <= drain_q + 32'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dut_pi      = pi_q;
   assign busy        = (state_q == StSweep) || (state_q == StDrain);
   assign done        = (state_q == StDone);
   assign pass        = done && (wce_q <= Limit);
   assign wce         = wce_q;
   assign err_count   = cnt_q;
   assign sum_abs_err = sum_q;
   assign fail_vector = fail_vec_q;

endmodule

// File: tb/tb_approx_adder_sweep_checker.sv
// Drives two checkers (combinational DUT, and registered DUT with DUT_LAT = 1) against an adder
// model given as a lookup table, and compares results with a reference computed arithmetically.
module tb_approx_adder_sweep_checker;

   logic clk = 1'b0;
   logic rst, start, abort_en;

   logic [3:0] pi0, pi1, fv0, fv1;
   logic [2:0] po0, po1, wce0, wce1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [4:0] cnt0, cnt1;
   logic [6:0] sum0, sum1;

   logic [2:0] dut_tab [16];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   approx_adder_sweep_checker #(.WIDTH(2), .WCE_LIMIT(2), .DUT_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .abort_en(abort_en),
      .dut_pi(pi0), .dut_po(po0), .busy(busy0), .done(done0), .pass(pass0),
      .wce(wce0), .err_count(cnt0), .sum_abs_err(sum0), .fail_vector(fv0)
   );

   approx_adder_sweep_checker #(.WIDTH(2), .WCE_LIMIT(2), .DUT_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .abort_en(abort_en),
      .dut_pi(pi1), .dut_po(po1), .busy(busy1), .done(done1), .pass(pass1),
      .wce(wce1), .err_count(cnt1), .sum_abs_err(sum1), .fail_vector(fv1)
   );

   // Adder under test: combinational for u_dut0, one register stage for u_dut1.
   assign po0 = dut_tab[pi0];
   always_ff @(posedge clk) po1 <= dut_tab[pi1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // 0 ideal, 1 bit 0 stuck at 0, 2 constant 0, 3 random corruption
   task automatic fill_tab(input int mode);
      for (int v = 0; v < 16; v++) begin
         logic [2:0] ex;
         ex = 3'((v % 4) + (v / 4));
         case (mode)
            0: dut_tab[v] = ex;
            1: dut_tab[v] = ex & 3'b110;
            2: dut_tab[v] = 3'd0;
            default: dut_tab[v] = ex ^ (($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
         endcase
      end
   endtask

   task automatic check_idle(input string p);
      check_eq({p, "_pi0"}, 32'(pi0), 0);
      check_eq({p, "_pi1"}, 32'(pi1), 0);
      check_eq({p, "_busy"}, 32'({busy0, busy1}), 0);
      check_eq({p, "_done"}, 32'({done0, done1}), 0);
      check_eq({p, "_pass"}, 32'({pass0, pass1}), 0);
      check_eq({p, "_wce"}, 32'({wce0, wce1}), 0);
      check_eq({p, "_cnt"}, 32'({cnt0, cnt1}), 0);
      check_eq({p, "_sum"}, 32'({sum0, sum1}), 0);
      check_eq({p, "_fv"}, 32'({fv0, fv1}), 0);
   endtask

   task automatic run_sweep(input string p, input bit abort, input bit poke);
      int e_wce, e_cnt, e_sum, e_fv, stop_v, d0, d1, cyc;
      bit hit, aborted;
      e_wce = 0; e_cnt = 0; e_sum = 0; e_fv = 0; stop_v = 15; hit = 0;
      for (int v = 0; v < 16; v++) begin
         int ex, got, e;
         ex  = (v % 4) + (v / 4);
         got = int'(dut_tab[v]);
         e   = (got > ex) ? got - ex : ex - got;
         if (e > e_wce) e_wce = e;
         if (e != 0) e_cnt++;
         e_sum += e;
         if (e > 2 && !hit) begin
            hit  = 1;
            e_fv = v;
         end
         if (abort && e > 2) begin
            stop_v = v;
            break;
         end
      end
      aborted = abort && hit;

      abort_en = abort;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; d0 = -1; d1 = -1;
      while (cyc < 100 && (d0 < 0 || d1 < 0)) begin
         if (done0 && d0 < 0) d0 = cyc;
         if (done1 && d1 < 0) d1 = cyc;
         if (cyc == 3 && !abort) begin
            check_eq({p, "_busy_mid"}, 32'({busy0, busy1}), 32'b11);
            check_eq({p, "_pass_mid"}, 32'({pass0, pass1, done0, done1}), 0);
         end
         start = poke && (cyc == 6);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      check_eq({p, "_done_cyc0"}, 32'(d0), 32'(aborted ? stop_v + 2 : 17));
      check_eq({p, "_done_cyc1"}, 32'(d1), 32'(aborted ? stop_v + 3 : 18));
      check_eq({p, "_pi0"}, 32'(pi0), 32'(aborted ? stop_v : 15));
      check_eq({p, "_pi1"}, 32'(pi1), 32'(aborted ? ((stop_v + 1 > 15) ? 15 : stop_v + 1) : 15));
      check_eq({p, "_done"}, 32'({done0, done1, busy0, busy1}), 32'b1100);
      check_eq({p, "_pass0"}, 32'(pass0), 32'(e_wce <= 2));
      check_eq({p, "_pass1"}, 32'(pass1), 32'(e_wce <= 2));
      check_eq({p, "_wce0"}, 32'(wce0), 32'(e_wce));
      check_eq({p, "_wce1"}, 32'(wce1), 32'(e_wce));
      check_eq({p, "_cnt0"}, 32'(cnt0), 32'(e_cnt));
      check_eq({p, "_cnt1"}, 32'(cnt1), 32'(e_cnt));
      check_eq({p, "_sum0"}, 32'(sum0), 32'(e_sum));
      check_eq({p, "_sum1"}, 32'(sum1), 32'(e_sum));
      check_eq({p, "_fv0"}, 32'(fv0), 32'(e_fv));
      check_eq({p, "_fv1"}, 32'(fv1), 32'(e_fv));
   endtask

   initial begin
      int waited;
      rst = 1'b1; start = 1'b0; abort_en = 1'b0;
      fill_tab(0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle("reset");

      run_sweep("ideal", 1'b0, 1'b0);
      fill_tab(1);
      run_sweep("bit0", 1'b0, 1'b0);
      fill_tab(2);
      run_sweep("zero_abort", 1'b1, 1'b0);
      fill_tab(2);
      run_sweep("zero_noabort", 1'b0, 1'b0);
      fill_tab(1);
      run_sweep("bit0_poke", 1'b0, 1'b1);

      // Reset in the middle of a sweep.
      fill_tab(0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (pi0 != 4'd5 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check_eq("midrst_reach5", 32'(pi0), 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("midrst");
      run_sweep("after_rst", 1'b0, 1'b0);

      for (int it = 0; it < 8; it++) begin
         fill_tab(3);
         run_sweep($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
